// File: rtl/afpm_host_driver.sv
// afpm_host_driver: host-side initiator for the byte-serial FP16 log-multiplier tile.
// Serialises an operand pair onto the tile's ui/uio pins as start, low and high bytes.
// It then captures the two result bytes from uo at the tile's fixed latency.
// Optional feature macro: AFPM_DRV_SKID_EN adds a 1-entry operand buffer, which lets the
// driver accept the next pair while a transaction is in flight.
module afpm_host_driver #(
  parameter logic [7:0]  START_TOKEN = 8'h01,
  parameter int unsigned RESP_LAT    = 10,
  parameter int unsigned RST_GUARD   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
  output logic [7:0]  dut_ui,
  output logic [7:0]  dut_uio,
  input  logic [7:0]  dut_uo
);

  localparam int unsigned GW = (RST_GUARD < 2) ? 1 : $clog2(RST_GUARD + 1);
  localparam logic [GW-1:0] GuardInit = GW'(RST_GUARD);
  // WAIT covers c3..c(RESP_LAT-1), so the down-counter runs RESP_LAT-4 .. 0.
  localparam logic [6:0] WaitInit = 7'(RESP_LAT - 4);

  if (START_TOKEN == 8'h00) begin : g_bad_token
    $error("afpm_host_driver: START_TOKEN must be non-zero");
  end
  if (RESP_LAT < 4) begin : g_bad_lat
    $error("afpm_host_driver: RESP_LAT must be at least 4");
  end

  typedef enum logic [3:0] {
    StGuard, StIdle, StStart, StSendLo, StSendHi, StWait, StCapLo, StCapHi, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [6:0]    wait_q, wait_d;
  logic [15:0]   a_q, a_d, b_q, b_d;
  logic [15:0]   res_q, res_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    ui_q, ui_d, uio_q, uio_d;
  logic          accept;

`ifdef AFPM_DRV_SKID_EN
  logic          buf_vld_q, buf_vld_d;
  logic [15:0]   buf_a_q, buf_a_d, buf_b_q, buf_b_d;

  assign in_ready = (state_q != StGuard) && !buf_vld_q;
`else
  assign in_ready = (state_q == StIdle);
`endif

  assign accept    = in_valid && in_ready;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign dut_ui    = ui_q;
  assign dut_uio   = uio_q;
  assign busy      = (state_q == StStart) || (state_q == StSendLo) || (state_q == StSendHi) ||
                     (state_q == StWait)  || (state_q == StCapLo)  || (state_q == StCapHi);

  // Next-state, operand latching, result capture and buffer management.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef AFPM_DRV_SKID_EN
    buf_vld_d = buf_vld_q;
    buf_a_d   = buf_a_q;
    buf_b_d   = buf_b_q;
`endif
    case (state_q)
      StGuard: begin
        if (guard_q <= GW'(1)) state_d = StIdle;
        else                   guard_d = guard_q - GW'(1);
      end
      StIdle: begin
`ifdef AFPM_DRV_SKID_EN
        if (buf_vld_q) begin
          a_d       = buf_a_q;
          b_d       = buf_b_q;
          buf_vld_d = 1'b0;
          state_d   = StStart;
        end else
`endif
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = StStart;
        end
      end
      StStart:  state_d = StSendLo;
      StSendLo: state_d = StSendHi;
      StSendHi: begin
        wait_d  = WaitInit;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == 7'd0) state_d = StCapLo;
        else                wait_d  = wait_q - 7'd1;
      end
      StCapLo: begin
        res_d[7:0] = dut_uo;
        state_d    = StCapHi;
      end
      StCapHi: begin
        res_d[15:8] = dut_uo;
        state_d     = StDone;
      end
      StDone: begin
        if (res_ready) begin
`ifdef AFPM_DRV_SKID_EN
          if (buf_vld_q) begin
            a_d       = buf_a_q;
            b_d       = buf_b_q;
            buf_vld_d = 1'b0;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StGuard;
    endcase
`ifdef AFPM_DRV_SKID_EN
    // Pairs accepted outside IDLE park in the buffer until the current result is taken.
    if (accept && (state_q != StIdle)) begin
      buf_vld_d = 1'b1;
      buf_a_d   = in_a;
      buf_b_d   = in_b;
    end
`endif
  end

  // Pin drive is registered from the next state so pins line up with the state cycle.
  always_comb begin
    ui_d  = 8'h00;
    uio_d = 8'h00;
    case (state_d)
      StStart:  ui_d = START_TOKEN;
      StSendLo: begin
        ui_d  = a_q[7:0];
        uio_d = b_q[7:0];
      end
      StSendHi: begin
        ui_d  = a_q[15:8];
        uio_d = b_q[15:8];
      end
      default: ;
    endcase
    res_valid_d = (state_d == StDone);
  end

  // State and output registers; reset aborts any transaction and re-enters GUARD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StGuard;
      guard_q     <= GuardInit;
      wait_q      <= 7'd0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      res_q       <= 16'h0000;
      res_valid_q <= 1'b0;
      ui_q        <= 8'h00;
      uio_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      wait_q      <= wait_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
    end
  end

`ifdef AFPM_DRV_SKID_EN
  // Skid buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q <= 1'b0;
      buf_a_q   <= 16'h0000;
      buf_b_q   <= 16'h0000;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_a_q   <= buf_a_d;
      buf_b_q   <= buf_b_d;
    end
  end
`endif

endmodule

// File: tb/tb_afpm_host_driver.sv
// tb_afpm_host_driver: directed self-checking bench with a behavioural tile model.
// The tile model returns known FP16 products for the reference pairs and
// a ^ byteswap(b) otherwise, so byte order and capture timing are observable.
module tb_afpm_host_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        busy;
  logic [7:0]  dut_ui, dut_uio, dut_uo;

  int checks = 0;
  int failures = 0;

  afpm_host_driver dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy),
    .dut_ui   (dut_ui),
    .dut_uio  (dut_uio),
    .dut_uo   (dut_uo)
  );

  always #5 clk = ~clk;

  // Tile model: tcnt == k during cycle ck (k >= 1) of the current transaction.
  int        cyc = 0;
  int        tcnt = 0;
  int        bad_ui = 0;
  int        starts[$];
  logic [7:0] cap0_uio, cap1_ui, cap1_uio, cap2_ui, cap2_uio;
  logic [15:0] tile_res;

  function automatic logic [15:0] tile_fn(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00 && b == 16'h4000) return 16'h4000;
    if (a == 16'hBC00 && b == 16'h3C00) return 16'hBC00;
    return a ^ {b[7:0], b[15:8]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      tcnt <= 0;
    end else begin
      if (dut_ui == 8'h01 && (tcnt == 0 || tcnt > 2)) begin
        tcnt     <= 1;
        cap0_uio <= dut_uio;
        starts.push_back(cyc);
      end else if (tcnt != 0 && tcnt < 60) begin
        tcnt <= tcnt + 1;
      end
      if (tcnt == 1) begin
        cap1_ui  <= dut_ui;
        cap1_uio <= dut_uio;
      end
      if (tcnt == 2) begin
        cap2_ui  <= dut_ui;
        cap2_uio <= dut_uio;
      end
      if (dut_ui != 8'h00 && dut_ui != 8'h01 && tcnt != 1 && tcnt != 2) bad_ui <= bad_ui + 1;
    end
  end

  always_comb begin
    tile_res = tile_fn({cap2_ui, cap1_ui}, {cap2_uio, cap1_uio});
    if (tcnt == 10)      dut_uo = tile_res[7:0];
    else if (tcnt == 11) dut_uo = tile_res[15:8];
    else                 dut_uo = 8'h5A;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    check_val({tag, "_res_valid"}, 32'(res_valid), 32'h0);
    check_val({tag, "_busy"}, 32'(busy), 32'h0);
    check_val({tag, "_dut_ui"}, 32'(dut_ui), 32'h0);
    check_val({tag, "_dut_uio"}, 32'(dut_uio), 32'h0);
    check_val({tag, "_res_data"}, 32'(res_data), 32'h0);
  endtask

  // Called at the negedge of reset release: 12 cycles of in_ready low, then high.
  task automatic guard_check();
    for (int i = 0; i < 12; i++) begin
      check_val("guard_in_ready_low", 32'(in_ready), 32'h0);
      @(negedge clk);
    end
    check_val("guard_in_ready_high", 32'(in_ready), 32'h1);
  endtask

  // Called at a negedge; returns at the negedge inside c0 of the accepted pair.
  task automatic send_op(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_timeout", 32'(n < 100), 32'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat = index of the negedge (counting the c0 one as 1) where res_valid is first seen.
  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_val("res_timeout", 32'(lat < 100), 32'h1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check_val("res_valid_drop", 32'(res_valid), 32'h0);
  endtask

  task automatic check_caps(input logic [15:0] a, input logic [15:0] b);
    check_val("c0_uio", 32'(cap0_uio), 32'h0);
    check_val("c1_ui", 32'(cap1_ui), 32'(a[7:0]));
    check_val("c1_uio", 32'(cap1_uio), 32'(b[7:0]));
    check_val("c2_ui", 32'(cap2_ui), 32'(a[15:8]));
    check_val("c2_uio", 32'(cap2_uio), 32'(b[15:8]));
  endtask

  logic [15:0] b2b_a [4] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h8002};
  logic [15:0] b2b_b [4] = '{16'h00FF, 16'h4000, 16'h0202, 16'h3C00};
  logic [15:0] b2b_r [4] = '{16'hED34, 16'h0040, 16'hFDFD, 16'h803E};

  initial begin
    int lat;
    int n0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    res_ready = 1'b0;
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    guard_check();

    // 1.0 * 2.0
    send_op(16'h3C00, 16'h4000);
    check_val("busy_c0", 32'(busy), 32'h1);
    check_val("ui_c0", 32'(dut_ui), 32'h01);
    wait_res(lat);
    check_val("lat_mul", 32'(lat), 32'd13);
    check_val("res_mul", 32'(res_data), 32'h4000);
    check_caps(16'h3C00, 16'h4000);
    handshake();

    // Sign, with res_ready held high before res_valid (no effect until valid).
    res_ready = 1'b1;
    send_op(16'hBC00, 16'h3C00);
    wait_res(lat);
    check_val("lat_sign", 32'(lat), 32'd13);
    check_val("res_sign", 32'(res_data), 32'hBC00);
    check_caps(16'hBC00, 16'h3C00);
    @(negedge clk);
    res_ready = 1'b0;
    check_val("sign_drop", 32'(res_valid), 32'h0);

`ifndef AFPM_DRV_SKID_EN
    // Backpressure with a pending pair held on the input.
    send_op(16'h3C00, 16'h4000);
    wait_res(lat);
    in_a     = 16'hBC00;
    in_b     = 16'h3C00;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_val("bp_valid", 32'(res_valid), 32'h1);
      check_val("bp_data", 32'(res_data), 32'h4000);
      check_val("bp_ui", 32'(dut_ui), 32'h0);
      check_val("bp_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
    end
    n0 = starts.size();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check_val("bp_idle_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_res(lat);
    check_val("bp_lat", 32'(lat), 32'd13);
    check_val("bp_res2", 32'(res_data), 32'hBC00);
    handshake();
    check_val("bp_single_accept", 32'(starts.size() - n0), 32'd1);
`endif

    // Reset at c5 aborts the transaction.
    send_op(16'h1234, 16'h00FF);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    guard_check();
    send_op(16'h3C00, 16'h4000);
    wait_res(lat);
    check_val("rst_lat", 32'(lat), 32'd13);
    check_val("rst_res", 32'(res_data), 32'h4000);
    handshake();

    // Back-to-back with res_ready tied high.
    res_ready = 1'b1;
    n0 = starts.size();
    for (int i = 0; i < 4; i++) begin
      send_op(b2b_a[i], b2b_b[i]);
      wait_res(lat);
`ifndef AFPM_DRV_SKID_EN
      check_val("b2b_lat", 32'(lat), 32'd13);
`endif
      check_val("b2b_res", 32'(res_data), 32'(b2b_r[i]));
      check_caps(b2b_a[i], b2b_b[i]);
    end
    @(negedge clk);
    res_ready = 1'b0;
    check_val("b2b_starts", 32'(starts.size() - n0), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (starts.size() >= n0 + 4)
        check_val("b2b_spacing", 32'((starts[n0+i] - starts[n0+i-1]) >= 13), 32'h1);
    end

`ifdef AFPM_DRV_SKID_EN
    // Second pair at c4 is buffered; third waits for the first handshake.
    send_op(b2b_a[0], b2b_b[0]);
    repeat (4) @(negedge clk);
    check_val("skid_ready_c4", 32'(in_ready), 32'h1);
    send_op(b2b_a[1], b2b_b[1]);
    in_a     = b2b_a[2];
    in_b     = b2b_b[2];
    in_valid = 1'b1;
    lat = 0;
    while (!res_valid && lat < 100) begin
      check_val("skid_full_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      lat++;
    end
    check_val("skid_res1", 32'(res_data), 32'(b2b_r[0]));
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check_val("skid_ready_after", 32'(in_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_res(lat);
    check_val("skid_res2", 32'(res_data), 32'(b2b_r[1]));
    handshake();
    wait_res(lat);
    check_val("skid_res3", 32'(res_data), 32'(b2b_r[2]));
    handshake();
`endif

    check_val("ui_outside_c0_c2", 32'(bad_ui), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
